// File: rtl/uart_rx.sv
//==============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with midpoint sampling, framing-error flag,
//            break handling and a running 32-bit checksum of good bytes.
//            Optional 2-flop input synchronizer under `UART_RX_SYNC_EN`.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx #(
  parameter int cycles_per_bit = 4
) (
  input  logic        clock,
  input  logic        i_rstn,
  input  logic        i_serial,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic [31:0] o_sum
);

  // Counter width; a 1-bit counter is the floor so the legal minimum
  // (two cycles per bit) still has a usable register.
  localparam int CW = (cycles_per_bit > 2) ? $clog2(cycles_per_bit) : 1;

  // Reload values, truncated to the counter width.
  localparam logic [CW-1:0] C_HALF_M1 = CW'((cycles_per_bit / 2) - 1);
  localparam logic [CW-1:0] C_FULL_M1 = CW'(cycles_per_bit - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cycle;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shreg;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic [31:0]     r_sum;
  logic            w_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer; resets to the idle line level so that reset
  // release never looks like a start edge.
  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_serial};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = i_serial;
`endif

  // Receive state machine: start detection, midpoint sampling, stop check,
  // registered result/pulse outputs and checksum accumulation.
  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_cycle     <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_sum       <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_s) begin
            r_state <= S_START;
            r_cycle <= C_HALF_M1;
          end
        end

        S_START: begin
          if (r_cycle != '0) begin
            r_cycle <= r_cycle - C_ONE;
          end else if (!w_s) begin
            // Start bit still low at its midpoint: a real frame.
            r_state   <= S_DATA;
            r_cycle   <= C_FULL_M1;
            r_bit_idx <= 3'd0;
          end else begin
            // Line went back high before midpoint: glitch, discard silently.
            r_state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (r_cycle != '0) begin
            r_cycle <= r_cycle - C_ONE;
          end else begin
            r_shreg <= {w_s, r_shreg[7:1]};
            r_cycle <= C_FULL_M1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

        S_STOP: begin
          if (r_cycle != '0) begin
            r_cycle <= r_cycle - C_ONE;
          end else if (w_s) begin
            // Good frame; returning to IDLE now lets a start bit that
            // immediately follows a single stop bit be caught.
            r_data  <= r_shreg;
            r_valid <= 1'b1;
            r_sum   <= r_sum + {24'b0, r_shreg};
            r_state <= S_IDLE;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_BREAK;
          end
        end

        S_BREAK: begin
          // Hold off until the line returns high so a stuck-low line is
          // not decoded as a stream of zero bytes.
          if (w_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_sum       = r_sum;

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmitter and consumes its 8N1 serial stream (1 start bit, 8 data bits LSB-first, stop bit(s) high). Detects the start edge, samples each bit at its midpoint with a down-counting cycle timer, and presents each received byte with a one-cycle valid strobe. Keeps a running 32-bit checksum of good bytes for test and demo readback, and flags framing errors.

## Interface
- `cycles_per_bit`, default 4: clock cycles per serial bit. Must match the transmitter. Legal range is >= 2.
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `i_rstn`  input  1  reset, asynchronous and active-low; clears all state immediately.
- `i_serial`  input  1  serial line; idle level is 1.
- `o_data`  output  8  last good byte; held until the next good byte.
- `o_valid`  output  1  one-cycle pulse when `o_data` is updated.
- `o_frame_err`  output  1  one-cycle pulse when a stop bit samples 0.
- `o_sum`  output  32  running sum of all good bytes, modulo 2^32.

## Operation
- Internal signals:
  - `cycle` is a `$clog2(cycles_per_bit)`-bit down-counter.
  - `bit_idx` is 3 bits.
  - `shreg` is 8 bits.
  - `half = cycles_per_bit/2`, using integer division.
- `s` is the serial sample: `i_serial` direct, or the synchronizer output (see Configuration).
- States and transitions:
  - **IDLE**: if `s==0`, go to START and set `cycle = half-1`.
  - **START**: if `cycle!=0`, decrement. At `cycle==0`, re-sample:
    - `s==0`: go to DATA with `cycle = cycles_per_bit-1` and `bit_idx = 0`.
    - `s==1`: treat as a glitch and return to IDLE. No outputs fire.
  - **DATA**: if `cycle!=0`, decrement. At `cycle==0`:
    - shift in `shreg = {s, shreg[7:1]}`;
    - if `bit_idx==7`, go to STOP with `cycle = cycles_per_bit-1`;
    - otherwise increment `bit_idx` and set `cycle = cycles_per_bit-1`.
  - **STOP**: if `cycle!=0`, decrement. At `cycle==0`:
    - `s==1`: `o_data <= shreg`, `o_valid <= 1`, `o_sum <= o_sum + {24'b0, shreg}`, go to IDLE.
    - `s==0`: `o_frame_err <= 1`. `o_data` and `o_sum` are unchanged. Go to BREAK.
  - **BREAK**: wait until `s==1`, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 bytes.
- `o_valid` and `o_frame_err` are registered pulses. They are 0 in every cycle other than the one following the qualifying STOP sample, and are never both 1.
- Checksum addition wraps silently at 2^32. There is no saturation and no carry out.
- Counter arithmetic: truncate constants to the counter width. A cycle counter at 0 is reloaded, never decremented.

## Timing
- Reset value of every register and output is 0, and the state is IDLE. Synchronizer flops reset to 1.
- Reset asserted mid-frame aborts immediately: the partial byte is discarded and no pulse is issued. After release, the receiver waits in IDLE for a fresh falling edge.
- Sample points are relative to t0, the first cycle with `s==0`:
  - start bit is re-checked at t0+`half`;
  - data bit n is sampled at t0+`half`+(n+1)·`cycles_per_bit`;
  - stop bit is sampled at t0+`half`+9·`cycles_per_bit`.
- `o_valid` is high in cycle t0+`half`+9·`cycles_per_bit`+1. For the default parameter this is t0+39.
- The receiver is in IDLE again in the same cycle `o_valid` is high. A start edge in that cycle is detected. This supports back-to-back frames with a single stop bit.
- Extra stop bits (line held high) simply keep the receiver in IDLE.

## Configuration
- `UART_RX_SYNC_EN`:
  - Defined: `i_serial` passes through a 2-flop synchronizer, reset to 1, before use. All latencies above grow by 2 cycles. This is required when `i_serial` comes from a pin or an asynchronous domain.
  - Undefined: `i_serial` is used directly with no added latency. Legal only when the driver is synchronous to `clock`, e.g. the on-chip transmitter.

## Test plan
- Reset, then drive an 8N1 frame of 0x48 (`cycles_per_bit`=4, macro off, start edge at t0) -> `o_valid` pulses only at t0+39, `o_data`=0x48, `o_sum`=0x00000048, `o_frame_err` stays 0.
- Back-to-back frames 0x65 then 0x6C, one stop bit each, no gap -> two `o_valid` pulses 40 cycles apart, final `o_sum`=0x000000D1.
- `i_serial` low for 1 cycle only, then high -> START rejects it as a glitch, no pulse, state returns to IDLE. A following 0x21 frame is received correctly.
- Frame 0x5A with stop bit forced 0, line held low 20 more cycles, then high -> single `o_frame_err` pulse, no `o_valid`, `o_data` and `o_sum` unchanged. A subsequent 0x33 frame is received correctly.
- Assert `i_rstn` low during data bit 4 of a frame, release, then send 0x7E -> all outputs are 0 immediately on assertion, and only 0x7E is reported with `o_sum`=0x7E.
- Macro on, repeat the first scenario -> `o_valid` at t0+41, same data and sum.
